// File: rtl/decode_stage.sv
// Decode stage: IF/ID register, 32-entry register file, MIPS-style decode, registered ID/EX bundle.
// Latency 1 edge D->E; StallF (load-use or HALT) holds fetch and D while E takes bubbles.
module decode_stage #(
    parameter int BUS_WIDTH  = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [BUS_WIDTH-1:0]  F_Instr,
    input  logic [BUS_WIDTH-1:0]  F_PC,
    input  logic                  F_Valid,
    input  logic                  FlushD,
    input  logic                  WB_En,
    input  logic [REG_ADDR_W-1:0] WB_Addr,
    input  logic [BUS_WIDTH-1:0]  WB_Data,
    output logic                  StallF,
    output logic                  Halted,
    output logic                  E_Valid,
    output logic [BUS_WIDTH-1:0]  E_PC,
    output logic [5:0]            E_Opcode,
    output logic [REG_ADDR_W-1:0] E_Rs,
    output logic [REG_ADDR_W-1:0] E_Rt,
    output logic [REG_ADDR_W-1:0] E_Rd,
    output logic [5:0]            E_Funct,
    output logic [BUS_WIDTH-1:0]  E_Imm,
    output logic [BUS_WIDTH-1:0]  E_RsData,
    output logic [BUS_WIDTH-1:0]  E_RtData,
    output logic                  E_RegWrite,
    output logic                  E_MemRead,
    output logic                  E_MemWrite,
    output logic                  E_Branch
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_HALT  = 6'h3F;
    localparam int         NUM_REGS = 2 ** REG_ADDR_W;

    logic                  d_vld;
    logic [BUS_WIDTH-1:0]  d_instr;
    logic [BUS_WIDTH-1:0]  d_pc;
    logic [BUS_WIDTH-1:0]  rf [NUM_REGS];

    logic [5:0]            d_opcode;
    logic [5:0]            d_funct;
    logic [REG_ADDR_W-1:0] d_rs;
    logic [REG_ADDR_W-1:0] d_rt;
    logic [REG_ADDR_W-1:0] d_rd;
    logic [BUS_WIDTH-1:0]  d_imm;
    logic [BUS_WIDTH-1:0]  rs_dat;
    logic [BUS_WIDTH-1:0]  rt_dat;
    logic                  uses_rs, uses_rt;
    logic                  reg_write, mem_read, mem_write, branch;
    logic                  is_halt;
    logic                  hazard;
    logic                  e_bubble;

    assign d_opcode = d_instr[31:26];
    assign d_rs     = d_instr[21 +: REG_ADDR_W];
    assign d_rt     = d_instr[16 +: REG_ADDR_W];
    assign d_rd     = d_instr[11 +: REG_ADDR_W];
    assign d_funct  = d_instr[5:0];
    assign d_imm    = {{(BUS_WIDTH-16){d_instr[15]}}, d_instr[15:0]};
    assign is_halt  = d_vld && (d_opcode == OP_HALT);

    always_comb begin
        uses_rs   = 1'b0;
        uses_rt   = 1'b0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        branch    = 1'b0;
        case (d_opcode)
            OP_RTYPE: begin reg_write = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
            OP_ADDI:  begin reg_write = 1'b1; uses_rs = 1'b1; end
            OP_LW:    begin reg_write = 1'b1; mem_read = 1'b1; uses_rs = 1'b1; end
            OP_SW:    begin mem_write = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
            OP_BEQ:   begin branch = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
            default:  ;
        endcase
    end

    // Write-before-read: a same-cycle write-back to the read index is forwarded.
    always_comb begin
        rs_dat = rf[d_rs];
        if (d_rs == '0)
            rs_dat = '0;
        else if (WB_En && (WB_Addr == d_rs))
            rs_dat = WB_Data;
        rt_dat = rf[d_rt];
        if (d_rt == '0)
            rt_dat = '0;
        else if (WB_En && (WB_Addr == d_rt))
            rt_dat = WB_Data;
    end

    assign hazard = d_vld && E_Valid && E_MemRead && (E_Rt != '0) &&
                    (((E_Rt == d_rs) && uses_rs) || ((E_Rt == d_rt) && uses_rt));
    assign StallF   = hazard || Halted;
    assign e_bubble = FlushD || hazard || Halted;

    always_ff @(posedge CLK) begin
        if (RST || FlushD) begin
            d_vld   <= 1'b0;
            d_instr <= '0;
            d_pc    <= '0;
        end else if (!StallF) begin
            d_vld   <= F_Valid;
            d_instr <= F_Instr;
            d_pc    <= F_PC;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_REGS; i++)
                rf[i] <= '0;
        end else if (WB_En && (WB_Addr != '0)) begin
            rf[WB_Addr] <= WB_Data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || e_bubble) begin
            E_Valid    <= 1'b0;
            E_PC       <= '0;
            E_Opcode   <= '0;
            E_Rs       <= '0;
            E_Rt       <= '0;
            E_Rd       <= '0;
            E_Funct    <= '0;
            E_Imm      <= '0;
            E_RsData   <= '0;
            E_RtData   <= '0;
            E_RegWrite <= 1'b0;
            E_MemRead  <= 1'b0;
            E_MemWrite <= 1'b0;
            E_Branch   <= 1'b0;
        end else begin
            E_Valid    <= d_vld;
            E_PC       <= d_pc;
            E_Opcode   <= d_opcode;
            E_Rs       <= d_rs;
            E_Rt       <= d_rt;
            E_Rd       <= d_rd;
            E_Funct    <= d_funct;
            E_Imm      <= d_imm;
            E_RsData   <= rs_dat;
            E_RtData   <= rt_dat;
            E_RegWrite <= reg_write && d_vld;
            E_MemRead  <= mem_read && d_vld;
            E_MemWrite <= mem_write && d_vld;
            E_Branch   <= branch && d_vld;
        end
    end

    // Halted latches on the same edge a valid HALT lands in E.
    always_ff @(posedge CLK) begin
        if (RST)
            Halted <= 1'b0;
        else if (!e_bubble && is_halt)
            Halted <= 1'b1;
    end
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus a randomized run against a pipeline-level model.
module tb_decode_stage;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] F_Instr = '0;
    logic [31:0] F_PC = '0;
    logic        F_Valid = 1'b0;
    logic        FlushD = 1'b0;
    logic        WB_En = 1'b0;
    logic [4:0]  WB_Addr = '0;
    logic [31:0] WB_Data = '0;
    logic        StallF, Halted, E_Valid;
    logic [31:0] E_PC, E_Imm, E_RsData, E_RtData;
    logic [5:0]  E_Opcode, E_Funct;
    logic [4:0]  E_Rs, E_Rt, E_Rd;
    logic        E_RegWrite, E_MemRead, E_MemWrite, E_Branch;

    decode_stage #(.BUS_WIDTH(32), .REG_ADDR_W(5)) dut (
        .CLK(CLK), .RST(RST), .F_Instr(F_Instr), .F_PC(F_PC), .F_Valid(F_Valid),
        .FlushD(FlushD), .WB_En(WB_En), .WB_Addr(WB_Addr), .WB_Data(WB_Data),
        .StallF(StallF), .Halted(Halted), .E_Valid(E_Valid), .E_PC(E_PC),
        .E_Opcode(E_Opcode), .E_Rs(E_Rs), .E_Rt(E_Rt), .E_Rd(E_Rd), .E_Funct(E_Funct),
        .E_Imm(E_Imm), .E_RsData(E_RsData), .E_RtData(E_RtData),
        .E_RegWrite(E_RegWrite), .E_MemRead(E_MemRead), .E_MemWrite(E_MemWrite),
        .E_Branch(E_Branch)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  funct;
        logic [31:0] imm, rsd, rtd;
        logic        rw, mr, mw, br;
    } e_t;

    e_t dut_e;
    assign dut_e = {E_Valid, E_PC, E_Opcode, E_Rs, E_Rt, E_Rd, E_Funct, E_Imm,
                    E_RsData, E_RtData, E_RegWrite, E_MemRead, E_MemWrite, E_Branch};

    int n_tests = 0;
    int n_fail  = 0;

    // Pipeline-level reference model state
    logic        m_dv;
    logic [31:0] m_di, m_dpc;
    e_t          m_e;
    logic        m_halt;
    logic [31:0] m_rf [32];

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; FlushD = 1'b0; WB_En = 1'b0; F_Valid = 1'b0;
        cycle();
        RST = 1'b0;
    endtask

    task automatic feed(input logic [31:0] ins, input logic [31:0] pc);
        F_Instr = ins; F_PC = pc; F_Valid = 1'b1;
    endtask

    function automatic logic [1:0] uses(input logic [5:0] op);
        case (op)
            6'h00, 6'h2B, 6'h04: return 2'b11;
            6'h08, 6'h23:        return 2'b10;
            default:             return 2'b00;
        endcase
    endfunction

    function automatic logic model_hz();
        logic [4:0] rs, rt;
        logic [1:0] u;
        rs = m_di[25:21]; rt = m_di[20:16]; u = uses(m_di[31:26]);
        return m_dv && m_e.valid && m_e.mr && (m_e.rt != 0) &&
               ((m_e.rt == rs && u[1]) || (m_e.rt == rt && u[0]));
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] r);
        if (r == 0) return 32'd0;
        if (WB_En && WB_Addr == r) return WB_Data;
        return m_rf[r];
    endfunction

    task automatic model_edge();
        e_t   ne;
        logic stall, bub;
        logic [5:0] op;
        if (RST) begin
            m_dv = 0; m_di = 0; m_dpc = 0; m_e = '0; m_halt = 0;
            for (int i = 0; i < 32; i++) m_rf[i] = 0;
            return;
        end
        op    = m_di[31:26];
        stall = model_hz() || m_halt;
        bub   = FlushD || stall;
        ne    = '0;
        if (!bub) begin
            ne.valid = m_dv; ne.pc = m_dpc; ne.op = op;
            ne.rs = m_di[25:21]; ne.rt = m_di[20:16]; ne.rd = m_di[15:11];
            ne.funct = m_di[5:0];
            ne.imm = {{16{m_di[15]}}, m_di[15:0]};
            ne.rsd = model_read(m_di[25:21]);
            ne.rtd = model_read(m_di[20:16]);
            if (m_dv) begin
                case (op)
                    6'h00, 6'h08: ne.rw = 1;
                    6'h23: begin ne.rw = 1; ne.mr = 1; end
                    6'h2B: ne.mw = 1;
                    6'h04: ne.br = 1;
                    default: ;
                endcase
                if (op == 6'h3F) m_halt = 1;
            end
        end
        if (FlushD) begin
            m_dv = 0; m_di = 0; m_dpc = 0;
        end else if (!stall) begin
            m_dv = F_Valid; m_di = F_Instr; m_dpc = F_PC;
        end
        if (WB_En && WB_Addr != 0) m_rf[WB_Addr] = WB_Data;
        m_e = ne;
    endtask

    function automatic logic [31:0] gen_instr();
        logic [5:0] op;
        case ($urandom_range(0, 7))
            0: op = 6'h00;
            1: op = 6'h08;
            2, 3: op = 6'h23;
            4: op = 6'h2B;
            5: op = 6'h04;
            6: op = 6'h3E;
            default: op = ($urandom_range(0, 3) == 0) ? 6'h3F : 6'($urandom);
        endcase
        return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 11'($urandom)};
    endfunction

    task automatic test_reset();
        do_reset();
        n_tests++; if (dut_e !== '0) begin n_fail++; $display("FAIL reset_e: got %h want 0", dut_e); end
        n_tests++; if ({Halted, StallF} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {Halted, StallF}); end
    endtask

    task automatic test_addi();
        do_reset();
        feed(32'h20010005, 32'h0);
        cycle();
        feed(32'h2001FFFF, 32'h4);
        cycle();
        n_tests++;
        if ({E_Valid, E_PC, E_Opcode, E_Rt, E_Imm, E_RegWrite, E_MemRead, E_MemWrite, E_Branch}
            !== {1'b1, 32'h0, 6'h08, 5'd1, 32'd5, 4'b1000}) begin
            n_fail++; $display("FAIL addi_pos: got v=%b pc=%h op=%h rt=%0d imm=%h ctl=%b", E_Valid, E_PC,
                               E_Opcode, E_Rt, E_Imm, {E_RegWrite, E_MemRead, E_MemWrite, E_Branch});
        end
        F_Valid = 1'b0;
        cycle();
        n_tests++; if ({E_Valid, E_PC, E_Imm} !== {1'b1, 32'h4, 32'hFFFFFFFF}) begin
            n_fail++; $display("FAIL addi_neg: got v=%b pc=%h imm=%h want 1/4/ffffffff", E_Valid, E_PC, E_Imm); end
    endtask

    task automatic test_regfile();
        do_reset();
        feed(32'h00602020, 32'h10);
        cycle();
        F_Valid = 1'b0; WB_En = 1'b1; WB_Addr = 5'd3; WB_Data = 32'hDEADBEEF;
        cycle();
        n_tests++; if ({E_Rs, E_RsData} !== {5'd3, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL bypass: got rs=%0d data=%h want 3/deadbeef", E_Rs, E_RsData); end
        WB_Addr = 5'd0; WB_Data = 32'd7;
        feed(32'h00002020, 32'h14);
        cycle();
        F_Valid = 1'b0; WB_En = 1'b0;
        cycle();
        n_tests++; if ({E_Valid, E_RsData, E_RtData} !== {1'b1, 64'd0}) begin
            n_fail++; $display("FAIL r0_read: got v=%b rs=%h rt=%h want 1/0/0", E_Valid, E_RsData, E_RtData); end
        feed(32'h00631020, 32'h18);
        cycle();
        F_Valid = 1'b0;
        cycle();
        n_tests++; if ({E_RsData, E_RtData} !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL rf_stored: got %h %h want deadbeef x2", E_RsData, E_RtData); end
    endtask

    task automatic test_load_use();
        do_reset();
        feed(32'h8C220000, 32'h20);
        cycle();
        feed(32'h00452020, 32'h24);
        cycle();
        n_tests++; if ({StallF, E_MemRead} !== 2'b11) begin
            n_fail++; $display("FAIL lu_stall: got stall=%b memrd=%b want 11", StallF, E_MemRead); end
        cycle();
        n_tests++; if ({E_Valid, StallF} !== 2'b00) begin
            n_fail++; $display("FAIL lu_bubble: got valid=%b stall=%b want 00", E_Valid, StallF); end
        F_Valid = 1'b0;
        cycle();
        n_tests++; if ({E_Valid, E_Opcode, E_Rs, E_PC} !== {1'b1, 6'h00, 5'd2, 32'h24}) begin
            n_fail++; $display("FAIL lu_resume: got v=%b op=%h rs=%0d pc=%h", E_Valid, E_Opcode, E_Rs, E_PC); end
        feed(32'h8C200000, 32'h28);
        cycle();
        feed(32'h00002020, 32'h2C);
        cycle();
        n_tests++; if (StallF !== 1'b0) begin
            n_fail++; $display("FAIL lu_r0: got stall=%b want 0", StallF); end
        F_Valid = 1'b0;
        cycle();
        n_tests++; if ({E_Valid, E_PC} !== {1'b1, 32'h2C}) begin
            n_fail++; $display("FAIL lu_r0_pass: got v=%b pc=%h want 1/2c", E_Valid, E_PC); end
    endtask

    task automatic test_flush_hazard();
        do_reset();
        feed(32'h8C220000, 32'h30);
        cycle();
        feed(32'h00452020, 32'h34);
        cycle();
        n_tests++; if (StallF !== 1'b1) begin
            n_fail++; $display("FAIL fl_pre: got stall=%b want 1", StallF); end
        FlushD = 1'b1;
        cycle();
        FlushD = 1'b0; F_Valid = 1'b0;
        n_tests++; if ({E_Valid, StallF} !== 2'b00) begin
            n_fail++; $display("FAIL fl_edge: got valid=%b stall=%b want 00", E_Valid, StallF); end
        cycle();
        n_tests++; if (E_Valid !== 1'b0) begin
            n_fail++; $display("FAIL fl_dclear: got valid=%b want 0", E_Valid); end
    endtask

    task automatic test_halt();
        do_reset();
        feed(32'hFC000000, 32'h40);
        cycle();
        feed(32'h20010005, 32'h44);
        n_tests++; if (Halted !== 1'b0) begin
            n_fail++; $display("FAIL halt_early: got %b want 0", Halted); end
        cycle();
        n_tests++; if ({Halted, StallF, E_Valid, E_Opcode} !== {3'b111, 6'h3F}) begin
            n_fail++; $display("FAIL halt_enter: got h=%b s=%b v=%b op=%h", Halted, StallF, E_Valid, E_Opcode); end
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_tests++; if ({Halted, StallF, E_Valid} !== 3'b110) begin
                n_fail++; $display("FAIL halt_hold%0d: got h=%b s=%b v=%b want 110", i, Halted, StallF, E_Valid); end
        end
        do_reset();
        n_tests++; if ({Halted, StallF, E_Valid} !== 3'b000) begin
            n_fail++; $display("FAIL halt_reset: got h=%b s=%b v=%b want 000", Halted, StallF, E_Valid); end
    endtask

    task automatic test_unknown_op();
        do_reset();
        feed(32'h8C220000, 32'h50);
        cycle();
        feed(32'hF8221234, 32'h54);
        cycle();
        n_tests++; if (StallF !== 1'b0) begin
            n_fail++; $display("FAIL unk_stall: got %b want 0", StallF); end
        F_Valid = 1'b0;
        cycle();
        n_tests++; if ({E_Valid, E_Opcode, E_RegWrite, E_MemRead, E_MemWrite, E_Branch} !== {1'b1, 6'h3E, 4'b0000}) begin
            n_fail++; $display("FAIL unk_decode: got v=%b op=%h ctl=%b", E_Valid, E_Opcode,
                               {E_RegWrite, E_MemRead, E_MemWrite, E_Branch}); end
    endtask

    task automatic test_random();
        RST = 1'b1; FlushD = 1'b0; WB_En = 1'b0; F_Valid = 1'b0;
        model_edge();
        cycle();
        for (int c = 0; c < 800; c++) begin
            RST     = ($urandom_range(0, 99) == 0) || (m_halt && $urandom_range(0, 5) == 0);
            FlushD  = ($urandom_range(0, 9) == 0);
            WB_En   = 1'($urandom_range(0, 1));
            WB_Addr = 5'($urandom_range(0, 4));
            WB_Data = $urandom;
            F_Instr = gen_instr();
            F_PC    = $urandom;
            F_Valid = ($urandom_range(0, 4) != 0);
            #1;
            n_tests++; if (StallF !== (model_hz() || m_halt)) begin
                n_fail++; $display("FAIL rnd_stall c%0d: got %b want %b", c, StallF, model_hz() || m_halt); end
            model_edge();
            cycle();
            n_tests++; if (dut_e !== m_e) begin
                n_fail++; $display("FAIL rnd_e c%0d: got %h want %h", c, dut_e, m_e); end
            n_tests++; if (Halted !== m_halt) begin
                n_fail++; $display("FAIL rnd_halt c%0d: got %b want %b", c, Halted, m_halt); end
        end
        RST = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_regfile();
        test_load_use();
        test_flush_hazard();
        test_halt();
        test_unknown_op();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
